// File: rtl/ka_pkg.sv
// Shared definitions for the iterative Karatsuba multiplier: FSM states,
// step encoding and the partial-product shift schedule.
package ka_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step encoding: which operand halves feed the shared half multiplier.
  localparam logic [1:0] STEP_LL = 2'd0;  // X_lo * Y_lo
  localparam logic [1:0] STEP_LH = 2'd1;  // X_lo * Y_hi
  localparam logic [1:0] STEP_HL = 2'd2;  // X_hi * Y_lo
  localparam logic [1:0] STEP_HH = 2'd3;  // X_hi * Y_hi

  // Left shift applied to a step's partial product before accumulation.
  function automatic int unsigned shift_amt(input logic [1:0] step, input int unsigned w);
    int unsigned amt;
    case (step)
      STEP_LL:          amt = 0;
      STEP_LH, STEP_HL: amt = w / 2;
      default:          amt = w;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/ka_half.sv
// Combinational N x N unsigned Karatsuba multiplier. Recurses on N/2-bit
// halves and bottoms out at a gate-level 2x2 cell.
module ka_half #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_leaf
    logic pp00, pp01, pp10, pp11, c1;

    assign pp00 = a[0] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp10 = a[1] & b[0];
    assign pp11 = a[1] & b[1];
    assign c1   = pp01 & pp10;

    assign p[0] = pp00;
    assign p[1] = pp01 ^ pp10;
    assign p[2] = pp11 ^ c1;
    assign p[3] = pp11 & c1;
  end else begin : g_rec
    localparam int H = N / 2;

    logic [H-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic [H:0]     sa, sb;
    logic [N-1:0]   z0, z2, zm;
    logic [2*N-1:0] z0_w, z2_w, zm_w, sa_w, sb_w, mid_w, cross_w;

    assign {a_hi, a_lo} = a;
    assign {b_hi, b_lo} = b;
    assign sa = {1'b0, a_lo} + {1'b0, a_hi};
    assign sb = {1'b0, b_lo} + {1'b0, b_hi};

    ka_half #(.N(H)) u_lo  (.a(a_lo),      .b(b_lo),      .p(z0));
    ka_half #(.N(H)) u_hi  (.a(a_hi),      .b(b_hi),      .p(z2));
    ka_half #(.N(H)) u_mid (.a(sa[H-1:0]), .b(sb[H-1:0]), .p(zm));

    assign z0_w = {{N{1'b0}}, z0};
    assign z2_w = {{N{1'b0}}, z2};
    assign zm_w = {{N{1'b0}}, zm};
    assign sa_w = {{(2*N-H){1'b0}}, sa[H-1:0]};
    assign sb_w = {{(2*N-H){1'b0}}, sb[H-1:0]};

    // The sums are H+1 bits wide; only their low H bits go through the
    // recursive multiplier, so the carry bits are folded back in here.
    assign mid_w = zm_w
                 + ((sa[H] ? sb_w : '0) << H)
                 + ((sb[H] ? sa_w : '0) << H)
                 + ({{(2*N-1){1'b0}}, sa[H] & sb[H]} << N);

    assign cross_w = mid_w - z0_w - z2_w;
    assign p       = (z2_w << N) + (cross_w << H) + z0_w;
  end

endmodule

// File: rtl/ka_iter.sv
// Iterative W x W unsigned multiplier: one shared W/2 x W/2 multiplier over
// four steps (two in dual-lane mode), valid/ready on both sides.
module ka_iter #(
  parameter int W = 32
) (
  input  logic           iClk,
  input  logic           iRstn,
  input  logic           iValid,
  output logic           oReady,
  input  logic [W-1:0]   iX,
  input  logic [W-1:0]   iY,
  input  logic           iSimd,
  output logic           oValid,
  input  logic           iReady,
  output logic [2*W-1:0] oO
);

  import ka_pkg::*;

  localparam int H = W / 2;

  state_t         state, state_nxt;
  logic [W-1:0]   x_q, y_q;
  logic           simd_q;
  logic [1:0]     step_q;
  logic [2*W-1:0] acc;
  logic           accept;
  logic [H-1:0]   op_a, op_b;
  logic [W-1:0]   pp;
  logic [2*W-1:0] term;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) state_nxt = MUL;
      end
      MUL: begin
        if (step_q == STEP_HH) state_nxt = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        oReady = iReady;
        if (iReady) state_nxt = iValid ? MUL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = iValid & oReady;

  // Operand mux driven by the registered step, so the half multiplier sees
  // stable inputs for the whole cycle.
  always_comb begin
    op_a = x_q[H-1:0];
    op_b = y_q[H-1:0];
    case (step_q)
      STEP_LH: begin op_a = x_q[H-1:0]; op_b = y_q[W-1:H]; end
      STEP_HL: begin op_a = x_q[W-1:H]; op_b = y_q[H-1:0]; end
      STEP_HH: begin op_a = x_q[W-1:H]; op_b = y_q[W-1:H]; end
      default: ;
    endcase
  end

  ka_half #(.N(H)) u_half (
    .a (op_a),
    .b (op_b),
    .p (pp)
  );

  assign term = {{W{1'b0}}, pp} << shift_amt(step_q, W);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      x_q    <= '0;
      y_q    <= '0;
      simd_q <= 1'b0;
      step_q <= STEP_LL;
      acc    <= '0;
    end else if (accept) begin
      x_q    <= iX;
      y_q    <= iY;
      simd_q <= iSimd;
      step_q <= STEP_LL;
      acc    <= '0;
    end else if (state == MUL) begin
      acc <= acc + term;
      // Dual-lane mode has no cross terms: jump straight from LL to HH.
      if (simd_q && step_q == STEP_LL) step_q <= STEP_HH;
      else                             step_q <= step_q + 2'd1;
    end
  end

  assign oO = acc;

endmodule
